// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: REGWR, LOAD, STORE, NOP toward data memory and the RF.
// Optional MEM_TIMEOUT_EN aborts a memory access after TIMEOUT unacked cycles.
module mem_wb_stage #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [1:0]        wb_op,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        WB       = 2'd2
    } state_t;

    localparam logic [1:0] OP_REGWR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              accept;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_err_q, mem_err_d;
`endif

    assign accept = alu_valid && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        mem_err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (wb_op)
                        OP_REGWR: begin
                            state_d    = WB;
                            rf_waddr_d = wb_rd;
                            rf_wdata_d = alu_result;
                        end
                        OP_LOAD: begin
                            state_d    = MEM_WAIT;
                            mem_req_d  = 1'b1;
                            mem_we_d   = 1'b0;
                            mem_addr_d = alu_result;
                            rf_waddr_d = wb_rd;
                        end
                        OP_STORE: begin
                            state_d     = MEM_WAIT;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = alu_result;
                            mem_wdata_d = store_data;
                        end
                        default: ;
                    endcase
`ifdef MEM_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            MEM_WAIT: begin
                // An ack on the final timeout cycle still completes normally.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = WB;
                        rf_wdata_d = mem_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
            mem_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            mem_err_q   <= mem_err_d;
`endif
        end
    end

    assign alu_ready = (state_q == IDLE);
    assign rf_we     = (state_q == WB);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;

`ifdef MEM_TIMEOUT_EN
    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Downstream neighbour of the ALU: consumes each 16-bit ALU result plus a writeback opcode.
- Per opcode, does one of:
  - register write of the result;
  - data-memory load using the result as address, then register write of the loaded data;
  - data-memory store using the result as address;
  - no-op.
- Uses a 3-state FSM with a valid/ready handshake toward the ALU and a req/ack handshake toward data memory.
- Is the only writer of the register file.

Parameters:
- DATA_W, 16, datapath and memory word width.
- REG_AW, 3, register-file address width (8 registers).
- TIMEOUT, 15, maximum cycles waiting for mem_ack (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU result/opcode valid this cycle.
- alu_ready  out  1  stage can accept a new operation.
- alu_result  in  DATA_W  ALU result (write data or memory address).
- wb_op  in  2  00 REGWR, 01 LOAD, 10 STORE, 11 NOP.
- wb_rd  in  REG_AW  destination register (REGWR/LOAD).
- store_data  in  DATA_W  data for STORE.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  store data.
- mem_ack  in  1  memory completion; one-cycle pulse.
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle.
- rf_we  out  1  register-file write enable, one-cycle pulse.
- rf_waddr  out  REG_AW  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- mem_err  out  1  timeout pulse (constant 0 without MEM_TIMEOUT_EN).

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset values, applied at the first clk edge with rst_n=0: state=IDLE; alu_ready=1; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; rf_we=0; rf_waddr=0; rf_wdata=0; mem_err=0; timeout counter=0.
- Reset mid-operation: the in-flight operation is discarded; mem_req drops at that edge; no rf write occurs.
- alu_ready = (state==IDLE). An op is accepted on an edge where alu_valid && alu_ready. At acceptance, alu_result, wb_op, wb_rd and store_data are registered.
- States: IDLE, MEM_WAIT, WB.
- IDLE, on accept:
  - REGWR -> WB, with rf_wdata=alu_result and rf_waddr=wb_rd.
  - LOAD -> MEM_WAIT, with mem_req=1, mem_we=0, mem_addr=alu_result.
  - STORE -> MEM_WAIT, with mem_req=1, mem_we=1, mem_addr=alu_result, mem_wdata=store_data.
  - NOP -> stays in IDLE; no side effects.
- MEM_WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack=1 is sampled.
  - On ack, mem_req drops at that edge.
  - LOAD: latches rf_wdata=mem_rdata, goes to WB.
  - STORE: goes to IDLE.
- WB: rf_we=1 for exactly one cycle, then IDLE.
- Latency, counting the accept edge as cycle 0:
  - REGWR: rf_we high in cycle 1.
  - LOAD with ack at cycle k (k≥1): rf_we high in cycle k+1.
  - STORE with ack at cycle k: alu_ready high in cycle k+1.
- mem_ack while mem_req=0 is ignored.
- alu_valid while alu_ready=0 is ignored. The ALU must hold it.
- Throughput: one REGWR every 2 cycles; one NOP every cycle.
- No arithmetic on data. Addresses pass through unmodified; no wrap logic.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack.
  - When it reaches TIMEOUT with no ack: mem_req drops, mem_err pulses for 1 cycle, state goes to IDLE, and no rf write occurs (LOAD aborted).
  - An ack in the same cycle the count reaches TIMEOUT wins (normal completion, no mem_err).
- Undefined: MEM_WAIT waits indefinitely; mem_err tied to 0; no counter logic.

Test Plan:
- Reset: hold rst_n=0 for 2 edges mid-LOAD with mem_req=1 -> after the edge mem_req=0, rf_we=0, alu_ready=1, all outputs at reset values.
- REGWR: alu_result=16'h1234, wb_rd=3, valid 1 cycle -> next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h1234; alu_ready=0 during that cycle.
- LOAD: alu_result=16'h0040, wb_rd=5, mem_ack after 3 cycles with mem_rdata=16'hBEEF -> mem_req/mem_addr=16'h0040 held 3 cycles; rf_we pulse with rf_waddr=5, rf_wdata=16'hBEEF the cycle after ack.
- STORE: alu_result=16'h0010, store_data=16'hA5A5, immediate ack -> mem_we=1, mem_wdata=16'hA5A5; no rf_we; alu_ready=1 the cycle after ack.
- Back-to-back: NOP, NOP, REGWR(r1=7), with a stray mem_ack in IDLE -> NOPs accepted on consecutive cycles; single rf_we with r1=7; stray ack has no effect.
- MEM_TIMEOUT_EN, TIMEOUT=15: LOAD, never acked -> mem_err=1 for one cycle after 15 MEM_WAIT cycles, mem_req=0, no rf_we; next op accepted normally.
